text_overlay_ctrl: RTL and testbench

Screen-level controller for the text overlays of the VGA pipeline. It sequences the game screens (title, play, game over) and drives the `enable` inputs of the text drawers (start, score, game-over). It also arbitrates the single shared font ROM between those drawers by fixed priority. The ROM row byte comes back after the ROM read latency; the block aligns it with the delayed bit index and emits one text-pixel flag to the pixel mixer.

---
 rtl/text_overlay_ctrl.sv | 125 ++++++++++++
 tb/tb_text_overlay_ctrl.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/text_overlay_ctrl.sv
// text_overlay_ctrl: screen FSM, text drawer enables, font ROM arbiter and pixel alignment.
// Optional TEXT_BLINK_EN macro enables blinking of the title text.
module text_overlay_ctrl #(
   parameter int BLINK_FRAMES = 30,
   parameter int ROM_LAT = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        frame_tick,
   input  logic        btn_start,
   input  logic        game_over,
   input  logic [2:0]  req_on,
   input  logic [32:0] req_rom_addr,
   input  logic [8:0]  req_bit_addr,
   output logic [10:0] rom_addr,
   input  logic [7:0]  rom_data,
   output logic        en_start,
   output logic        en_score,
   output logic        en_over,
   output logic        text_on,
   output logic [1:0]  text_sel,
   output logic [1:0]  state
);
   typedef enum logic [1:0] {TITLE = 2'd0, PLAY = 2'd1, OVER = 2'd2} st_t;
   st_t st;
   logic btn_q, pend_go, pend_over, rise, go;
   logic [8:0] lock;
   logic [1:0] grant, grant_d;
   logic [2:0] bsel, bit_d;
   logic valid_d;
   logic [5:0] pipe [ROM_LAT];
`ifdef TEXT_BLINK_EN
   logic [7:0] cnt;
   logic phase, wrap;
   assign wrap = cnt == 8'(BLINK_FRAMES - 1);
`endif
   // edges during the game-over lockout are dropped, not deferred
   assign rise = btn_start & ~btn_q & ~(st == OVER && lock != 9'd0);
   assign go = pend_go | rise;
   assign state = st;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st <= TITLE;
         btn_q <= 1'b0;
         pend_go <= 1'b0;
         pend_over <= 1'b0;
         lock <= '0;
         en_start <= 1'b1;
         en_score <= 1'b0;
         en_over <= 1'b0;
`ifdef TEXT_BLINK_EN
         cnt <= '0;
         phase <= 1'b1;
`endif
      end else begin
         btn_q <= btn_start;
         pend_go <= pend_go | rise;
         pend_over <= pend_over | (game_over & (st == PLAY));
`ifdef TEXT_BLINK_EN
         en_start <= (st == TITLE) & phase;
`else
         en_start <= st == TITLE;
`endif
         en_score <= (st == PLAY) | (st == OVER);
         en_over <= st == OVER;
         case (st)
            TITLE: begin
`ifdef TEXT_BLINK_EN
               if (frame_tick) begin
                  cnt <= wrap ? '0 : cnt + 8'd1;
                  phase <= phase ^ wrap;
               end
`endif
               if (frame_tick & go) begin
                  st <= PLAY;
                  pend_go <= 1'b0;
                  pend_over <= 1'b0;
               end
            end
            PLAY: if (frame_tick & (pend_over | game_over)) begin
               st <= OVER;
               lock <= 9'(2 * BLINK_FRAMES);
               pend_go <= 1'b0;
               pend_over <= 1'b0;
            end
            OVER: begin
               if (frame_tick && lock != 9'd0) lock <= lock - 9'd1;
               if (frame_tick && go && lock == 9'd0) begin
                  st <= TITLE;
                  pend_go <= 1'b0;
                  pend_over <= 1'b0;
`ifdef TEXT_BLINK_EN
                  cnt <= '0;
                  phase <= 1'b1;
`endif
               end
            end
            default: begin
               st <= TITLE;
`ifdef TEXT_BLINK_EN
               cnt <= '0;
               phase <= 1'b1;
`endif
            end
         endcase
      end
   end
   // fixed priority 2 > 0 > 1
   assign grant = req_on[2] ? 2'd2 : req_on[0] ? 2'd0 : req_on[1] ? 2'd1 : 2'd3;
   assign rom_addr = req_on[2] ? req_rom_addr[32:22] : req_on[0] ? req_rom_addr[10:0] :
                     req_on[1] ? req_rom_addr[21:11] : 11'd0;
   assign bsel = req_on[2] ? req_bit_addr[8:6] : req_on[0] ? req_bit_addr[2:0] :
                 req_on[1] ? req_bit_addr[5:3] : 3'd0;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < ROM_LAT; i++) pipe[i] <= '0;
      end else begin
         pipe[0] <= {|req_on, grant, bsel};
         for (int i = 1; i < ROM_LAT; i++) pipe[i] <= pipe[i-1];
      end
   end
   assign {valid_d, grant_d, bit_d} = pipe[ROM_LAT-1];
   assign text_on = valid_d & rom_data[~bit_d];
   assign text_sel = valid_d ? grant_d : 2'd3;
endmodule

// File: tb/tb_text_overlay_ctrl.sv
// tb_text_overlay_ctrl: directed checks of screen FSM, lockout, blink, arbiter and alignment.
module tb_text_overlay_ctrl;
   logic clk = 0, rst = 1, frame_tick = 0, btn_start = 0, game_over = 0;
   logic [2:0] req_on = 0;
   logic [32:0] req_rom_addr = 0;
   logic [8:0] req_bit_addr = 0;
   logic [10:0] rom_addr;
   logic [7:0] rom_data = 0;
   logic en_start, en_score, en_over, text_on;
   logic [1:0] text_sel, state;
   int checks = 0, errors = 0;
   text_overlay_ctrl #(.BLINK_FRAMES(2), .ROM_LAT(1)) dut (
      .clk(clk), .rst(rst), .frame_tick(frame_tick), .btn_start(btn_start),
      .game_over(game_over), .req_on(req_on), .req_rom_addr(req_rom_addr),
      .req_bit_addr(req_bit_addr), .rom_addr(rom_addr), .rom_data(rom_data),
      .en_start(en_start), .en_score(en_score), .en_over(en_over),
      .text_on(text_on), .text_sel(text_sel), .state(state)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask
   task automatic frame();
      frame_tick = 1;
      step(1);
      frame_tick = 0;
   endtask
   task automatic press();
      btn_start = 1;
      step(1);
      btn_start = 0;
      step(1);
   endtask
   task automatic pulse_over();
      game_over = 1;
      step(1);
      game_over = 0;
      step(1);
   endtask
   initial begin
      logic [3:0] blink_exp;
`ifdef TEXT_BLINK_EN
      blink_exp = 4'b1001;
`else
      blink_exp = 4'b1111;
`endif
      step(2);
      rst = 0;
      step(2);
      chk("rst_state", 32'(state), 0);
      chk("rst_en_start", 32'(en_start), 1);
      chk("rst_en_score", 32'(en_score), 0);
      chk("rst_en_over", 32'(en_over), 0);
      chk("rst_text_on", 32'(text_on), 0);
      chk("rst_text_sel", 32'(text_sel), 3);
      chk("arb_none_addr", 32'(rom_addr), 0);
      req_rom_addr = {11'h30, 11'h20, 11'h10};
      req_bit_addr = {3'd0, 3'd5, 3'd3};
      req_on = 3'b111;
      #1 chk("arb_all_addr", 32'(rom_addr), 32'h30);
      step(1);
      rom_data = 8'h80;
      #1 chk("arb_all_on", 32'(text_on), 1);
      chk("arb_all_sel", 32'(text_sel), 2);
      req_on = 3'b011;
      #1 chk("arb_01_addr", 32'(rom_addr), 32'h10);
      step(1);
      rom_data = 8'h10;
      #1 chk("arb_01_on", 32'(text_on), 1);
      chk("arb_01_sel", 32'(text_sel), 0);
      req_on = 3'b010;
      #1 chk("arb_1_addr", 32'(rom_addr), 32'h20);
      step(1);
      #1 chk("arb_1_on", 32'(text_on), 0);
      chk("arb_1_sel", 32'(text_sel), 1);
      req_on = 3'b000;
      step(1);
      chk("arb_idle_on", 32'(text_on), 0);
      chk("arb_idle_sel", 32'(text_sel), 3);
      for (int i = 0; i < 4; i++) begin
         frame();
         step(1);
         chk($sformatf("blink_%0d", i), 32'(en_start), 32'(blink_exp[3-i]));
      end
      btn_start = 1;
      step(1);
      chk("defer_mid", 32'(state), 0);
      step(3);
      chk("defer_mid2", 32'(state), 0);
      frame();
      chk("defer_tick", 32'(state), 1);
      chk("defer_en_lag", 32'(en_score), 0);
      step(1);
      chk("defer_en_score", 32'(en_score), 1);
      chk("defer_en_start", 32'(en_start), 0);
      btn_start = 0;
      pulse_over();
      step(2);
      chk("over_wait", 32'(state), 1);
      frame();
      chk("over_tick", 32'(state), 2);
      step(1);
      chk("over_en_over", 32'(en_over), 1);
      chk("over_en_score", 32'(en_score), 1);
      for (int i = 0; i < 4; i++) begin
         press();
         frame();
         chk($sformatf("lockout_%0d", i), 32'(state), 2);
      end
      frame();
      chk("lockout_nolatch", 32'(state), 2);
      press();
      chk("lockout_pend", 32'(state), 2);
      frame();
      chk("over_to_title", 32'(state), 0);
      step(1);
      chk("title_en_start", 32'(en_start), 1);
      chk("title_en_over", 32'(en_over), 0);
      btn_start = 1;
      frame_tick = 1;
      step(1);
      btn_start = 0;
      frame_tick = 0;
      chk("same_tick_go", 32'(state), 1);
      game_over = 1;
      frame_tick = 1;
      step(1);
      game_over = 0;
      frame_tick = 0;
      chk("same_tick_over", 32'(state), 2);
      step(1);
      rst = 1;
      #1 chk("async_rst_state", 32'(state), 0);
      chk("async_rst_en_over", 32'(en_over), 0);
      chk("async_rst_en_start", 32'(en_start), 1);
      rst = 0;
      step(1);
      pulse_over();
      for (int i = 0; i < 3; i++) begin
         frame();
         chk($sformatf("title_ignore_go_%0d", i), 32'(state), 0);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
